// File: rtl/ifft_out_unloader.sv
// Single-buffer unloader: captures one frame of IFFT results, then streams it out
// in natural index order (optionally bit-reversed read) with rounding and saturation.
module ifft_out_unloader #(
    parameter int N      = 32,
    parameter int IW     = 36,
    parameter int OW     = 29,
    parameter int FRAC   = 4,
    parameter bit BITREV = 1'b1,
    localparam int AW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_re,
    input  logic [IW-1:0] in_im,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_re,
    output logic [OW-1:0] out_im,
    output logic [AW-1:0] out_idx,
    output logic          out_last,
    output logic          out_sat,
    output logic          frame_err
);

    typedef enum logic {FILL, DRAIN} state_t;

    localparam logic signed [IW:0] HALF = (IW+1)'(2 ** (FRAC - 1));
    localparam logic signed [IW:0] SMAX = {{(IW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW:0] SMIN = {{(IW-OW+2){1'b1}}, {(OW-1){1'b0}}};

    state_t             state;
    logic [AW-1:0]      wcnt;
    logic [AW-1:0]      rcnt;
    logic [AW-1:0]      rd_idx;
    logic [AW-1:0]      rd_addr;
    logic [2*IW-1:0]    mem [N];
    logic [2*IW-1:0]    rd_data;
    logic [OW:0]        re_rs;
    logic [OW:0]        im_rs;
    logic               wr_en;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    // Returns {saturated, value}; the sum is one bit wider so the rounding add cannot overflow.
    function automatic logic [OW:0] round_sat(input logic [IW-1:0] x);
        logic signed [IW:0] t;
        logic signed [IW:0] s;
        t = {x[IW-1], x} + HALF;
        s = t >>> FRAC;
        if (s > SMAX) begin
            return {1'b1, 1'b0, {(OW-1){1'b1}}};
        end else if (s < SMIN) begin
            return {1'b1, 1'b1, {(OW-1){1'b0}}};
        end else begin
            return {1'b0, s[OW-1:0]};
        end
    endfunction

    assign wr_en = (state == FILL) && in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wcnt] <= {in_re, in_im};
        end
    end

    // While a sample is held, the read port already looks one index ahead for the reload.
    always_comb begin
        rd_idx  = out_valid ? rcnt + AW'(1) : rcnt;
        rd_addr = BITREV ? bitrev(rd_idx) : rd_idx;
        rd_data = mem[rd_addr];
        re_rs   = round_sat(rd_data[2*IW-1:IW]);
        im_rs   = round_sat(rd_data[IW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            wcnt      <= '0;
            rcnt      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                FILL: begin
                    if (in_valid && in_ready) begin
                        if (wcnt == AW'(N - 1)) begin
                            frame_err <= !in_last;
                            wcnt      <= '0;
                            rcnt      <= '0;
                            in_ready  <= 1'b0;
                            state     <= DRAIN;
                        end else if (in_last) begin
                            frame_err <= 1'b1;
                            wcnt      <= '0;
                        end else begin
                            wcnt <= wcnt + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid || out_ready) begin
                        if (out_valid && out_last) begin
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            rcnt      <= '0;
                            state     <= FILL;
                        end else begin
                            out_valid <= 1'b1;
                            rcnt      <= rd_idx;
                            out_idx   <= rd_idx;
                            out_last  <= (rd_idx == AW'(N - 1));
                            out_re    <= re_rs[OW-1:0];
                            out_im    <= im_rs[OW-1:0];
                            out_sat   <= re_rs[OW] | im_rs[OW];
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_ifft_out_unloader.sv
// Bench for ifft_out_unloader: bit-reversed and natural-order instances share stimulus,
// each checked against its own queue of expected output samples.
module tb_ifft_out_unloader;

    localparam int N  = 32;
    localparam int IW = 36;
    localparam int OW = 29;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_last;
    logic          out_ready;
    logic [IW-1:0] in_re;
    logic [IW-1:0] in_im;

    logic          in_ready_n, out_valid_n, out_last_n, out_sat_n, frame_err_n;
    logic [OW-1:0] out_re_n, out_im_n;
    logic [AW-1:0] out_idx_n;
    logic          in_ready_r, out_valid_r, out_last_r, out_sat_r, frame_err_r;
    logic [OW-1:0] out_re_r, out_im_r;
    logic [AW-1:0] out_idx_r;

    typedef struct {
        logic [OW-1:0] re;
        logic [OW-1:0] im;
        logic [AW-1:0] idx;
        logic          last;
        logic          sat;
    } exp_t;

    typedef struct {
        logic [IW-1:0] re;
        logic [IW-1:0] im;
        logic [OW-1:0] exp_re;
        logic [OW-1:0] exp_im;
        logic          exp_sat;
    } vec_t;

    exp_t          q_n[$];
    exp_t          q_r[$];
    vec_t          vecs[8];
    logic [IW-1:0] frm_re[N];
    logic [IW-1:0] frm_im[N];
    logic [OW-1:0] fe_re[N];
    logic [OW-1:0] fe_im[N];
    logic          fe_sat[N];
    int            tests_run = 0;
    int            tests_failed = 0;
    int            cyc;
    int            first;

    ifft_out_unloader #(.N(N), .IW(IW), .OW(OW), .FRAC(4), .BITREV(1'b0)) u_dut_nat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_n), .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_re(out_re_n), .out_im(out_im_n),
        .out_idx(out_idx_n), .out_last(out_last_n), .out_sat(out_sat_n), .frame_err(frame_err_n)
    );

    ifft_out_unloader #(.N(N), .IW(IW), .OW(OW), .FRAC(4), .BITREV(1'b1)) u_dut_rev (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_r), .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_re(out_re_r), .out_im(out_im_r),
        .out_idx(out_idx_r), .out_last(out_last_r), .out_sat(out_sat_r), .frame_err(frame_err_r)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: bound expired or expected data missing", name);
    endtask

    function automatic logic [AW-1:0] rev5(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
        return r;
    endfunction

    task automatic loadRamp();
        for (int k = 0; k < N; k++) begin
            frm_re[k] = IW'(k * 16);
            frm_im[k] = IW'(-(k * 16));
            fe_re[k]  = OW'(k);
            fe_im[k]  = OW'(-k);
            fe_sat[k] = 1'b0;
        end
    endtask

    task automatic loadTable();
        for (int k = 0; k < N; k++) begin
            frm_re[k] = '0;
            frm_im[k] = '0;
            fe_re[k]  = '0;
            fe_im[k]  = '0;
            fe_sat[k] = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            frm_re[k] = vecs[k].re;
            frm_im[k] = vecs[k].im;
            fe_re[k]  = vecs[k].exp_re;
            fe_im[k]  = vecs[k].exp_im;
            fe_sat[k] = vecs[k].exp_sat;
        end
    endtask

    // Output j of the natural instance is sample j; of the reversed instance, sample rev5(j).
    task automatic pushFrame();
        int k;
        for (int j = 0; j < N; j++) begin
            q_n.push_back('{fe_re[j], fe_im[j], AW'(j), (j == N - 1), fe_sat[j]});
            k = int'(rev5(AW'(j)));
            q_r.push_back('{fe_re[k], fe_im[k], AW'(j), (j == N - 1), fe_sat[k]});
        end
    endtask

    task automatic applyStimulus(input int n, input int last_at, input bit exp_err);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_re    = frm_re[k];
            in_im    = frm_im[k];
            in_last  = (k == last_at);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_re    = '0;
        in_im    = '0;
        @(negedge clk);
        cmp("frame_err_nat", frame_err_n, 64'(exp_err));
        cmp("frame_err_rev", frame_err_r, 64'(exp_err));
        cmp("in_ready_after_write_nat", in_ready_n, 64'(n != N));
        cmp("in_ready_after_write_rev", in_ready_r, 64'(n != N));
        cmp("latency_valid_low_nat", out_valid_n, 0);
        cmp("latency_valid_low_rev", out_valid_r, 0);
        @(posedge clk); #1;
        if (exp_err) begin
            @(negedge clk);
            cmp("frame_err_single_pulse_nat", frame_err_n, 0);
            cmp("frame_err_single_pulse_rev", frame_err_r, 0);
            cmp("valid_after_err_nat", out_valid_n, 64'(n == N));
            cmp("valid_after_err_rev", out_valid_r, 64'(n == N));
            @(posedge clk); #1;
        end
    endtask

    task automatic checkOutput(input bit rev, input bit pop, input logic v, input logic [OW-1:0] re,
                               input logic [OW-1:0] im, input logic [AW-1:0] idx, input logic last,
                               input logic sat);
        exp_t  e;
        string tag;
        tag = rev ? "rev" : "nat";
        if ((rev && q_r.size() == 0) || (!rev && q_n.size() == 0)) begin
            failNow({tag, "_queue_empty"});
            return;
        end
        if (rev) e = pop ? q_r.pop_front() : q_r[0];
        else     e = pop ? q_n.pop_front() : q_n[0];
        cmp({tag, "_out_valid"}, v, 1);
        cmp({tag, "_out_re"}, re, e.re);
        cmp({tag, "_out_im"}, im, e.im);
        cmp({tag, "_out_idx"}, idx, e.idx);
        cmp({tag, "_out_last"}, last, e.last);
        cmp({tag, "_out_sat"}, sat, e.sat);
    endtask

    // A held sample is compared against the queue head without popping, so it must stay unchanged.
    task automatic drainFrame(input int count, input bit toggle, output int cycles, output int first_v);
        int got;
        int c;
        got = 0;
        c = 0;
        first_v = -1;
        out_ready = 1'b1;
        while (got < count && c < 4 * N + 8) begin
            @(negedge clk);
            if (out_valid_n || out_valid_r) begin
                if (first_v < 0) first_v = c;
                checkOutput(1'b0, out_ready, out_valid_n, out_re_n, out_im_n, out_idx_n, out_last_n, out_sat_n);
                checkOutput(1'b1, out_ready, out_valid_r, out_re_r, out_im_r, out_idx_r, out_last_r, out_sat_r);
                if (out_ready) got++;
            end
            if (got < count) begin
                @(posedge clk); #1;
                c++;
                if (toggle) out_ready = ~out_ready;
            end
        end
        if (got < count) failNow("drain_timeout");
        cycles = c;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic checkIdle(input string name);
        @(negedge clk);
        cmp({name, "_in_ready_nat"}, in_ready_n, 1);
        cmp({name, "_in_ready_rev"}, in_ready_r, 1);
        cmp({name, "_out_valid_nat"}, out_valid_n, 0);
        cmp({name, "_out_valid_rev"}, out_valid_r, 0);
        @(posedge clk); #1;
    endtask

    task automatic checkReset(input string name);
        cmp({name, "_in_ready_nat"}, in_ready_n, 1);
        cmp({name, "_in_ready_rev"}, in_ready_r, 1);
        cmp({name, "_outs_nat"}, {out_valid_n, out_re_n, out_im_n, out_idx_n, out_last_n, out_sat_n, frame_err_n}, 0);
        cmp({name, "_outs_rev"}, {out_valid_r, out_re_r, out_im_r, out_idx_r, out_last_r, out_sat_r, frame_err_r}, 0);
    endtask

    initial begin
        vecs[0] = '{36'h8,          36'h7,          29'h1,        29'h0,        1'b0};
        vecs[1] = '{36'hF_FFFF_FFF8, 36'hF_FFFF_FFF7, 29'h0,        29'h1FFFFFFF, 1'b0};
        vecs[2] = '{36'h4_0000_0000, 36'h0,          29'h0FFFFFFF, 29'h0,        1'b1};
        vecs[3] = '{36'h0,          36'h8_0000_0000, 29'h0,        29'h10000000, 1'b1};
        vecs[4] = '{36'h0_FFFF_FFF7, 36'hF_0000_0000, 29'h0FFFFFFF, 29'h10000000, 1'b0};
        vecs[5] = '{36'h0_FFFF_FFF8, 36'h0,          29'h0FFFFFFF, 29'h0,        1'b1};
        vecs[6] = '{36'h0,          36'hE_FFFF_FFF7, 29'h0,        29'h10000000, 1'b1};
        vecs[7] = '{36'h18,         36'hF_FFFF_FFE8, 29'h2,        29'h1FFFFFFF, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_re = '0;
        in_im = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkReset("por");
        @(posedge clk); #1;
        rst = 1'b0;

        // Ramp frame, downstream always ready
        loadRamp();
        pushFrame();
        applyStimulus(N, N - 1, 1'b0);
        drainFrame(N, 1'b0, cyc, first);
        cmp("b2b_first_valid", 64'(first), 0);
        cmp("b2b_cycles", 64'(cyc), 31);
        checkIdle("b2b_idle");

        // Ramp frame, ready alternating every cycle
        loadRamp();
        pushFrame();
        applyStimulus(N, N - 1, 1'b0);
        drainFrame(N, 1'b1, cyc, first);
        cmp("toggle_cycles", 64'(cyc), 62);
        checkIdle("toggle_idle");

        // Rounding and saturation vectors
        loadTable();
        pushFrame();
        applyStimulus(N, N - 1, 1'b0);
        drainFrame(N, 1'b0, cyc, first);
        checkIdle("arith_idle");

        // Early in_last discards the partial frame, then a clean frame follows
        loadRamp();
        applyStimulus(10, 9, 1'b1);
        pushFrame();
        applyStimulus(N, N - 1, 1'b0);
        drainFrame(N, 1'b0, cyc, first);
        checkIdle("early_last_idle");

        // Missing in_last still drains the frame
        loadRamp();
        pushFrame();
        applyStimulus(N, -1, 1'b1);
        drainFrame(N, 1'b0, cyc, first);
        checkIdle("no_last_idle");

        // Reset while out_idx = 12 in DRAIN, then a fresh frame
        loadRamp();
        pushFrame();
        applyStimulus(N, N - 1, 1'b0);
        drainFrame(12, 1'b0, cyc, first);
        rst = 1'b1;
        @(negedge clk);
        cmp("pre_reset_idx_nat", out_idx_n, 12);
        cmp("pre_reset_idx_rev", out_idx_r, 12);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkReset("mid_drain_reset");
        @(posedge clk); #1;
        q_n.delete();
        q_r.delete();
        loadTable();
        pushFrame();
        applyStimulus(N, N - 1, 1'b0);
        drainFrame(N, 1'b0, cyc, first);
        checkIdle("post_reset_idle");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
